// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the iteration phase.
module div_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  Start_i,
  input  logic [1:0]            DivOp_i,
  input  logic [DATA_WIDTH-1:0] SrcA_i,
  input  logic [DATA_WIDTH-1:0] SrcB_i,
  input  logic                  Flush_i,
  output logic                  Busy_o,
  output logic                  Valid_o,
  output logic [DATA_WIDTH-1:0] Result_o
);

  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] div_q, div_d;
  logic [DATA_WIDTH-1:0] a_raw_q, a_raw_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  rem_sel_q, rem_sel_d;
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;
  logic                  div_zero_q, div_zero_d;
  logic                  ovf_q, ovf_d;
  logic                  busy_q, busy_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;

  logic                  op_signed;
  logic                  in_div_zero;
  logic                  in_ovf;
  logic [DATA_WIDTH-1:0] a_abs;
  logic [DATA_WIDTH-1:0] b_abs;
  logic [DATA_WIDTH:0]   rem_shift;
  logic [DATA_WIDTH:0]   rem_sub;
  logic                  rem_ge;
  logic [DATA_WIDTH-1:0] step_rem;
  logic [DATA_WIDTH-1:0] step_quo;
  logic [DATA_WIDTH-1:0] fix_rem;
  logic [DATA_WIDTH-1:0] fix_quo;

  // Special-case results; for div-by-zero the remainder is the raw dividend.
  function automatic logic [DATA_WIDTH-1:0] special_res(input logic                  rem_sel,
                                                        input logic [DATA_WIDTH-1:0] a,
                                                        input logic                  dz);
    if (dz) begin
      special_res = rem_sel ? a : {DATA_WIDTH{1'b1}};
    end else begin
      special_res = rem_sel ? {DATA_WIDTH{1'b0}} : a;
    end
  endfunction

  always_comb begin
    op_signed   = ~DivOp_i[0];
    in_div_zero = (SrcB_i == '0);
    in_ovf      = op_signed && (SrcA_i == {1'b1, {(DATA_WIDTH-1){1'b0}}}) &&
                  (SrcB_i == {DATA_WIDTH{1'b1}});
    a_abs       = (op_signed && SrcA_i[DATA_WIDTH-1]) ? (~SrcA_i + 1'b1) : SrcA_i;
    b_abs       = (op_signed && SrcB_i[DATA_WIDTH-1]) ? (~SrcB_i + 1'b1) : SrcB_i;

    rem_shift = {rem_q, quo_q[DATA_WIDTH-1]};
    rem_ge    = (rem_shift >= {1'b0, div_q});
    rem_sub   = rem_shift - {1'b0, div_q};
    step_rem  = rem_ge ? rem_sub[DATA_WIDTH-1:0] : rem_shift[DATA_WIDTH-1:0];
    step_quo  = {quo_q[DATA_WIDTH-2:0], rem_ge};
    fix_quo   = neg_quo_q ? (~step_quo + 1'b1) : step_quo;
    fix_rem   = neg_rem_q ? (~step_rem + 1'b1) : step_rem;
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    div_d      = div_q;
    a_raw_d    = a_raw_q;
    cnt_d      = cnt_q;
    rem_sel_d  = rem_sel_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    result_d   = result_q;

    if (Flush_i) begin
      state_d = StIdle;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (Start_i) begin
            rem_sel_d  = DivOp_i[1];
            quo_d      = a_abs;
            div_d      = b_abs;
            a_raw_d    = SrcA_i;
            rem_d      = '0;
            neg_quo_d  = op_signed & (SrcA_i[DATA_WIDTH-1] ^ SrcB_i[DATA_WIDTH-1]);
            neg_rem_d  = op_signed & SrcA_i[DATA_WIDTH-1];
            div_zero_d = in_div_zero;
            ovf_d      = in_ovf;
            cnt_d      = CntW'(DATA_WIDTH - 1);
            state_d    = StCalc;
            busy_d     = 1'b1;
`ifdef DIV_EARLY_OUT_EN
            if (in_div_zero || in_ovf) begin
              state_d  = StDone;
              valid_d  = 1'b1;
              result_d = special_res(DivOp_i[1], SrcA_i, in_div_zero);
            end
`endif
          end
        end
        StCalc: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = StDone;
            valid_d = 1'b1;
            if (div_zero_q || ovf_q) begin
              result_d = special_res(rem_sel_q, a_raw_q, div_zero_q);
            end else begin
              result_d = rem_sel_q ? fix_rem : fix_quo;
            end
          end
        end
        StDone: begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      rem_q      <= '0;
      quo_q      <= '0;
      div_q      <= '0;
      a_raw_q    <= '0;
      cnt_q      <= '0;
      rem_sel_q  <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      div_q      <= div_d;
      a_raw_q    <= a_raw_d;
      cnt_q      <= cnt_d;
      rem_sel_q  <= rem_sel_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      result_q   <= result_d;
    end
  end

  // A flush landing on the DONE cycle suppresses the pulse immediately.
  assign Valid_o  = valid_q & ~Flush_i;
  assign Busy_o   = busy_q;
  assign Result_o = result_q;

endmodule
